// File: rtl/prob_argmax_reader.sv
`default_nettype none
// ============================================================================
// Module   : prob_argmax_reader
// Purpose  : Scans the classifier score RAM, tracks the running maximum and
//            publishes the winning digit and its score. Optional 7-segment
//            decode of the digit is built when SEVEN_SEG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module prob_argmax_reader #(
  parameter int NUM_CLASSES = 10,
  parameter int PROB_W      = 16,
  parameter int ADDR_W      = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PROB_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [3:0]        digit,
  output logic [PROB_W-1:0] max_prob,
  output logic [7:0]        hex_out
);

  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(NUM_CLASSES - 1);
  localparam logic [ADDR_W-1:0] C_ONE       = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_DRAIN   = 2'd2,
    S_PUBLISH = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_cap_valid;
  logic [ADDR_W-1:0]   r_cap_addr;
  logic [PROB_W-1:0]   r_run_max;
  logic [ADDR_W-1:0]   r_run_idx;
  logic [3:0]          r_digit;
  logic [PROB_W-1:0]   r_max_prob;
  logic                r_result_valid;
  logic                w_take;
  logic [PROB_W-1:0]   w_max_nxt;
  logic [ADDR_W-1:0]   w_idx_nxt;
  logic [3:0]          w_digit_nxt;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    rd_en       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_READ;
      end
      S_READ: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (r_addr == C_LAST_ADDR) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = S_PUBLISH;
      end
      S_PUBLISH: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strict compare keeps the lowest index on ties; data lags its address by one cycle.
  assign w_take      = r_cap_valid && (rd_data > r_run_max);
  assign w_max_nxt   = w_take ? rd_data    : r_run_max;
  assign w_idx_nxt   = w_take ? r_cap_addr : r_run_idx;
  assign w_digit_nxt = 4'(w_idx_nxt);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_addr         <= '0;
      r_cap_valid    <= 1'b0;
      r_cap_addr     <= '0;
      r_run_max      <= '0;
      r_run_idx      <= '0;
      r_digit        <= '0;
      r_max_prob     <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_cap_valid <= rd_en;
      if (rd_en) r_cap_addr <= r_addr;
      r_run_max <= w_max_nxt;
      r_run_idx <= w_idx_nxt;
      case (r_state)
        S_IDLE: begin
          r_run_max <= '0;
          r_run_idx <= '0;
          if (start) r_addr <= '0;
        end
        S_READ: begin
          if (r_addr != C_LAST_ADDR) r_addr <= r_addr + C_ONE;
        end
        S_DRAIN: begin
          // Load result with the final capture folded in so it is visible alongside done.
          r_digit        <= w_digit_nxt;
          r_max_prob     <= w_max_nxt;
          r_result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_addr      = r_addr;
  assign digit        = r_digit;
  assign max_prob     = r_max_prob;
  assign result_valid = r_result_valid;

`ifdef SEVEN_SEG_EN
  logic [7:0] r_hex;

  function automatic logic [7:0] f_seg(input logic [3:0] d);
    logic [7:0] seg;
    case (d)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset)                 r_hex <= 8'hC0;
    else if (r_state == S_DRAIN) r_hex <= f_seg(w_digit_nxt);
  end

  assign hex_out = r_hex;
`else
  assign hex_out = 8'hFF;
`endif

endmodule
`default_nettype wire
